// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between a set of bus masters and bus_arbiter.
//
// Signals:
//   dma     [N_MASTERS]  per-master level-sensitive bus request
//   ready   [1]          slave completion strobe (meaningful while req=1)
//   grant   [N_MASTERS]  one-hot grant, all-zero when nobody owns the bus
//   req     [1]          high whenever grant is non-zero
//   owner   [OWNER_W]    binary index of the granted master, 0 when idle
//   timeout [1]          one-cycle pulse when the watchdog aborts a transfer
//
// Modports:
//   master  request side: drives dma/ready, observes the arbitration result
//   slave   arbiter side: consumes dma/ready, drives the arbitration result
// ----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int unsigned N_MASTERS = 8
);
    localparam int unsigned OWNER_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] dma;
    logic                 ready;
    logic [N_MASTERS-1:0] grant;
    logic                 req;
    logic [OWNER_W-1:0]   owner;
    logic                 timeout;

    modport master (
        output dma,
        output ready,
        input  grant,
        input  req,
        input  owner,
        input  timeout
    );

    modport slave (
        input  dma,
        input  ready,
        output grant,
        output req,
        output owner,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Single-owner bus arbiter with a two-state (IDLE/BUSY) transfer FSM.
// In IDLE the grant is the zero-latency arbitration of the live requests; a
// transfer that does not complete in its first cycle is latched and held in
// BUSY until ready (no preemption). Fixed priority (index 0 highest) or
// round-robin starting at a pointer that advances past each finished owner.
//
// Parameters:
//   N_MASTERS  number of masters, 2..16
//   RR_MODE    0 = fixed priority, 1 = round-robin
//   TIMEOUT    watchdog limit in stalled BUSY cycles, 2..65535
//
// Optional feature (macro BUS_ARB_TIMEOUT_EN):
//   defined   16-bit watchdog aborts a BUSY transfer stalled for TIMEOUT
//             cycles and pulses bus.timeout for one cycle
//   undefined no watchdog; bus.timeout is tied low
//
// Ports:
//   clk    system clock, rising edge
//   clr_n  asynchronous active-low reset; also masks grant/req/owner
//   bus    bus_arbiter_if.slave (dma, ready in; grant, req, owner, timeout out)
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned N_MASTERS = 8,
    parameter int unsigned RR_MODE   = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         clr_n,
    bus_arbiter_if.slave bus
);

    localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Elaboration-time parameter range checks
    if ((N_MASTERS < 2) || (N_MASTERS > 16)) begin : g_bad_n_masters
        $error("bus_arbiter: N_MASTERS must be in 2..16");
    end
    if (RR_MODE > 1) begin : g_bad_rr_mode
        $error("bus_arbiter: RR_MODE must be 0 or 1");
    end
    if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must be in 2..65535");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_MASTERS-1:0] r_grant;
    logic [N_MASTERS-1:0] w_win_oh;
    logic                 w_win_vld;
    logic [N_MASTERS-1:0] w_grant;
    logic [OW-1:0]        r_ptr;
    logic [OW-1:0]        w_start;
    logic [OW-1:0]        w_owner;
    logic [OW-1:0]        w_ptr_nxt;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_busy_enter;
    logic                 w_to_hit;
    logic                 w_timeout;

    // (base + off) mod N_MASTERS for off < N_MASTERS
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base,
                                               input int unsigned  off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_MASTERS) begin
            sum = sum - N_MASTERS;
        end
        return OW'(sum);
    endfunction

    // Fixed mode always searches from index 0
    assign w_start = (RR_MODE != 0) ? r_ptr : '0;

    // Search from w_start upward with wrap; first asserted request wins
    always_comb begin : p_arb
        w_win_vld = 1'b0;
        w_win_oh  = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (!w_win_vld && bus.dma[wrap_add(w_start, i)]) begin
                w_win_vld                   = 1'b1;
                w_win_oh[wrap_add(w_start, i)] = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge clr_n) begin : p_state
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_vld && !bus.ready) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.ready || w_to_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs and transfer events; ready beats the watchdog in BUSY
    always_comb begin : p_out
        w_grant      = '0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        w_busy_enter = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant      = w_win_oh;
                w_done       = w_win_vld && bus.ready;
                w_busy_enter = w_win_vld && !bus.ready;
            end
            BUSY: begin
                w_grant = r_grant;
                w_done  = bus.ready;
                w_abort = !bus.ready && w_to_hit;
            end
            default: w_grant = '0;
        endcase
        // Reset masks the bus result immediately, even between edges
        if (!clr_n) begin
            w_grant = '0;
        end
    end

    // Binary index of the current grant
    always_comb begin : p_owner
        w_owner = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_owner = w_owner | OW'(i);
            end
        end
    end

    assign w_ptr_nxt = wrap_add(w_owner, 1);

    // Latched winner held for the whole BUSY period
    always_ff @(posedge clk or negedge clr_n) begin : p_grant
        if (!clr_n) begin
            r_grant <= '0;
        end else if (w_busy_enter) begin
            r_grant <= w_win_oh;
        end else if (w_done || w_abort) begin
            r_grant <= '0;
        end
    end

    // Round-robin pointer moves past the owner of every finished transfer
    always_ff @(posedge clk or negedge clr_n) begin : p_ptr
        if (!clr_n) begin
            r_ptr <= '0;
        end else if (w_done || w_abort) begin
            r_ptr <= w_ptr_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_to_hit = (r_cnt == CNT_LAST);

    // Counts stalled BUSY cycles since the transfer was latched
    always_ff @(posedge clk or negedge clr_n) begin : p_cnt
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (w_busy_enter) begin
            r_cnt <= '0;
        end else if ((r_state == BUSY) && !bus.ready && !w_to_hit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin : p_timeout
        if (!clr_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort;
        end
    end

    assign w_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign w_timeout = 1'b0;
`endif

    assign bus.grant   = w_grant;
    assign bus.req     = |w_grant;
    assign bus.owner   = w_owner;
    assign bus.timeout = w_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
// Drives a fixed-priority and a round-robin bus_arbiter (N_MASTERS=8,
// TIMEOUT=4) with shared stimulus. A behavioural model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N  = 8;
    localparam int TO = 4;

    localparam int K_GRANT = 0;
    localparam int K_OWNER = 1;
    localparam int K_REQ   = 2;
    localparam int K_TO    = 3;

    typedef struct {
        logic [N-1:0] g0;
        logic [N-1:0] g1;
        int           o0;
        int           o1;
        logic         t0;
        logic         t1;
        string        dname;
        int           dmode;
        int           dkind;
        int           dval;
    } exp_t;

    logic         clk;
    logic         clr_n_s;
    logic [N-1:0] dma_s;
    logic         ready_s;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;

    // Model state, index 0 = fixed priority, 1 = round-robin
    int   m_busy [2];
    int   m_own  [2];
    int   m_ptr  [2];
    int   m_cnt  [2];
    logic m_to   [2];

    bus_arbiter_if #(.N_MASTERS(N)) bus_f ();
    bus_arbiter_if #(.N_MASTERS(N)) bus_r ();

    assign bus_f.dma   = dma_s;
    assign bus_f.ready = ready_s;
    assign bus_r.dma   = dma_s;
    assign bus_r.ready = ready_s;

    bus_arbiter #(.N_MASTERS(N), .RR_MODE(0), .TIMEOUT(TO)) u_fix (
        .clk   (clk),
        .clr_n (clr_n_s),
        .bus   (bus_f.slave)
    );

    bus_arbiter #(.N_MASTERS(N), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .clk   (clk),
        .clr_n (clr_n_s),
        .bus   (bus_r.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // First requester found scanning upward from start, wrapping; -1 if none
    function automatic int winner(input logic [N-1:0] d, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (d[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset(input int m);
        m_busy[m] = 0;
        m_own[m]  = 0;
        m_ptr[m]  = 0;
        m_cnt[m]  = 0;
        m_to[m]   = 1'b0;
    endfunction

    // Advance one rising edge using the inputs of the cycle just ended
    function automatic void model_step(input int m);
        int w;
        m_to[m] = 1'b0;
        if (m_busy[m] == 0) begin
            w = winner(dma_s, (m == 1) ? m_ptr[m] : 0);
            if (w >= 0) begin
                if (ready_s) begin
                    m_ptr[m] = (w + 1) % N;
                end else begin
                    m_busy[m] = 1;
                    m_own[m]  = w;
                    m_cnt[m]  = 0;
                end
            end
        end else if (ready_s) begin
            m_busy[m] = 0;
            m_ptr[m]  = (m_own[m] + 1) % N;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            m_cnt[m] = m_cnt[m] + 1;
            if (m_cnt[m] == TO) begin
                m_busy[m] = 0;
                m_ptr[m]  = (m_own[m] + 1) % N;
                m_to[m]   = 1'b1;
            end
`endif
        end
    endfunction

    function automatic int model_owner(input int m);
        if (!clr_n_s) return -1;
        if (m_busy[m] != 0) return m_own[m];
        return winner(dma_s, (m == 1) ? m_ptr[m] : 0);
    endfunction

    function automatic void push_expected(input string nm, input int md,
                                          input int kd, input int vl);
        exp_t e;
        int   o;
        o      = model_owner(0);
        e.g0   = (o >= 0) ? N'(1 << o) : '0;
        e.o0   = (o >= 0) ? o : 0;
        e.t0   = m_to[0];
        o      = model_owner(1);
        e.g1   = (o >= 0) ? N'(1 << o) : '0;
        e.o1   = (o >= 0) ? o : 0;
        e.t1   = m_to[1];
        e.dname = nm;
        e.dmode = md;
        e.dkind = kd;
        e.dval  = vl;
        q.push_back(e);
    endfunction

    // One clock: advance model at the edge, drive inputs 1 ns later, predict
    task automatic cycle(input logic [N-1:0] d, input logic r, input logic c,
                         input string nm = "", input int md = 0,
                         input int kd = 0, input int vl = 0);
        @(posedge clk);
        if (clr_n_s) begin
            model_step(0);
            model_step(1);
        end
        #1;
        dma_s   = d;
        ready_s = r;
        clr_n_s = c;
        if (!c) begin
            model_reset(0);
            model_reset(1);
        end
        push_expected(nm, md, kd, vl);
    endtask

    function automatic int act_of(input int md, input int kd);
        case (kd)
            K_GRANT: return (md != 0) ? int'(bus_r.grant)   : int'(bus_f.grant);
            K_OWNER: return (md != 0) ? int'(bus_r.owner)   : int'(bus_f.owner);
            K_REQ:   return (md != 0) ? int'(bus_r.req)     : int'(bus_f.req);
            default: return (md != 0) ? int'(bus_r.timeout) : int'(bus_f.timeout);
        endcase
    endfunction

    task automatic compare(input string nm, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle
    always @(negedge clk) begin : p_mon
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            compare("grant_fix",   act_of(0, K_GRANT), int'(mon_e.g0));
            compare("req_fix",     act_of(0, K_REQ),   (mon_e.g0 != '0) ? 1 : 0);
            compare("owner_fix",   act_of(0, K_OWNER), mon_e.o0);
            compare("timeout_fix", act_of(0, K_TO),    int'(mon_e.t0));
            compare("grant_rr",    act_of(1, K_GRANT), int'(mon_e.g1));
            compare("req_rr",      act_of(1, K_REQ),   (mon_e.g1 != '0) ? 1 : 0);
            compare("owner_rr",    act_of(1, K_OWNER), mon_e.o1);
            compare("timeout_rr",  act_of(1, K_TO),    int'(mon_e.t1));
            if (mon_e.dname != "") begin
                compare(mon_e.dname, act_of(mon_e.dmode, mon_e.dkind), mon_e.dval);
            end
        end
    end

    initial begin : p_stim
        n_checks = 0;
        n_errors = 0;
        clr_n_s  = 1'b0;
        dma_s    = '0;
        ready_s  = 1'b0;
        model_reset(0);
        model_reset(1);

        // Reset masks grant regardless of requests
        cycle(8'hFF, 1'b1, 1'b0, "rst_grant_masked", 0, K_GRANT, 0);
        cycle(8'hFF, 1'b0, 1'b0, "rst_req_masked",   1, K_REQ,   0);

        // Fixed priority, latched hold, no preemption, re-arbitration
        cycle(8'b0010_1100, 1'b0, 1'b1, "fix_grant",   0, K_GRANT, 'h04);
        cycle(8'b0000_0001, 1'b0, 1'b1, "fix_hold",    0, K_GRANT, 'h04);
        cycle(8'b0000_0001, 1'b1, 1'b1, "fix_owner",   0, K_OWNER, 2);
        cycle(8'b0000_0001, 1'b0, 1'b1, "fix_regrant", 0, K_GRANT, 'h01);
        cycle(8'b0000_0000, 1'b1, 1'b1);

        // Round-robin rotation with all masters requesting
        cycle(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b1, 1'b1, "rr_rotate_owner", 1, K_OWNER, i % 8);
        end

        // Round-robin pointer wrap after owner 7
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'b0100_0000, 1'b1, 1'b1, "rr_owner6",    1, K_OWNER, 6);
        cycle(8'b1000_0001, 1'b1, 1'b1, "rr_wrap_to7",  1, K_OWNER, 7);
        cycle(8'b1000_0001, 1'b1, 1'b1, "rr_wrap_to0",  1, K_OWNER, 0);
        cycle(8'b0000_0000, 1'b1, 1'b1);

        // Reset dropped between edges while master 3 owns the bus
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'b0000_1000, 1'b0, 1'b1, "rst_pre_owner", 1, K_OWNER, 3);
        cycle(8'b0000_1000, 1'b0, 1'b1, "rst_pre_busy",  0, K_OWNER, 3);
        #2;
        clr_n_s = 1'b0;
        model_reset(0);
        model_reset(1);
        q.delete(q.size() - 1);
        push_expected("rst_mid_grant", 1, K_GRANT, 0);
        cycle(8'h00, 1'b0, 1'b1, "rst_rel_grant", 1, K_GRANT, 0);
        cycle(8'h00, 1'b1, 1'b1, "rst_rel_req",   0, K_REQ,   0);

`ifdef BUS_ARB_TIMEOUT_EN
        // Watchdog abort after four stalled BUSY cycles, grant moves on
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'b0110_0000, 1'b0, 1'b1, "to_owner5", 1, K_OWNER, 5);
        for (int i = 0; i < 4; i++) begin
            cycle(8'b0110_0000, 1'b0, 1'b1, "to_quiet", 1, K_TO, 0);
        end
        cycle(8'b0110_0000, 1'b1, 1'b1, "to_pulse",      1, K_TO,    1);
        cycle(8'b0000_0000, 1'b0, 1'b1, "to_pulse_once", 1, K_TO,    0);

        // ready on the last permitted cycle wins over the watchdog
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'b0010_0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(8'b0010_0000, 1'b0, 1'b1);
        end
        cycle(8'b0010_0000, 1'b1, 1'b1, "to_ready_last", 1, K_OWNER, 5);
        cycle(8'b0000_0000, 1'b0, 1'b1, "to_suppressed", 1, K_TO,    0);
`endif

        // Randomised traffic with occasional resets
        for (int n = 0; n < 700; n++) begin
            logic [N-1:0] d;
            logic         r;
            logic         c;
            d = N'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & N'($urandom);
            if ($urandom_range(0, 5) == 0) d = '0;
            r = ($urandom_range(0, 99) < 40);
            c = ($urandom_range(0, 149) != 0);
            cycle(d, r, c);
        end
        cycle(8'h00, 1'b1, 1'b1);

        // Let the monitor consume the remaining predictions
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d predictions left, required 0", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
